// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer and data-memory port arbiter for the 8-bit single-cycle core.
//   Holds the core in reset while the host preloads dat_mem, releases it on req,
//   counts RUN cycles, ends the run on core_done or on the watchdog limit, then
//   freezes the core so the host can read results.
// Ports:
//   clk, reset (async, active-low)
//   req                               host run request (level)
//   host_we/host_addr/host_wdata      host dat_mem write port
//   core_done                         core reached end of program
//   core_we/core_addr/core_wdata      core dat_mem write port
//   dm_we/dm_addr/dm_wdata            muxed dat_mem port (combinational on state)
//   core_reset                        active-high reset to core PC/flags
//   busy, done, timeout               run status
//   cycles                            RUN cycles of last or current run
//   host_drop                         1-cycle pulse: host write ignored while core owns memory
module run_ctrl #(
  parameter int unsigned CW      = 16,
  parameter int unsigned MAX_CYC = 65535,
  parameter int unsigned RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          host_we,
  input  logic [7:0]    host_addr,
  input  logic [7:0]    host_wdata,
  input  logic          core_done,
  input  logic          core_we,
  input  logic [7:0]    core_addr,
  input  logic [7:0]    core_wdata,
  output logic          dm_we,
  output logic [7:0]    dm_addr,
  output logic [7:0]    dm_wdata,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic          host_drop
);

  // Down-counter wide enough to hold RST_CYC-1 (at least one bit).
  localparam int unsigned RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYC - 1);
  localparam logic [CW-1:0]  MAX_V    = CW'(MAX_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [RCW-1:0]  rcnt, rcnt_nxt;
  logic [CW-1:0]   cycles_nxt;
  logic            timeout_nxt;
  logic            core_reset_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic            host_drop_nxt;
  logic            core_own;

  // Core owns the memory port only while it is being started or running.
  assign core_own = (state == START) || (state == RUN);

  // Memory port mux; follows the registered state so async reset reverts to host at once.
  assign dm_we    = core_own ? core_we    : host_we;
  assign dm_addr  = core_own ? core_addr  : host_addr;
  assign dm_wdata = core_own ? core_wdata : host_wdata;

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    rcnt_nxt      = rcnt;
    cycles_nxt    = cycles;
    timeout_nxt   = timeout;
    host_drop_nxt = host_we && core_own;

    case (state)
      IDLE: begin
        if (req) begin
          state_nxt   = START;
          rcnt_nxt    = RST_LOAD;
          cycles_nxt  = '0;
          timeout_nxt = 1'b0;
        end
      end
      START: begin
        if (rcnt == '0) state_nxt = RUN;
        else            rcnt_nxt  = rcnt - RCW'(1);
      end
      RUN: begin
        // core_done takes priority over the watchdog on the same edge.
        if (core_done) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b0;
        end else if (cycles + CW'(1) == MAX_V) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
          cycles_nxt  = MAX_V;
        end else begin
          cycles_nxt  = cycles + CW'(1);
        end
      end
      DONE: begin
        // Stay frozen until req drops so a held req cannot retrigger a run.
        if (!req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    core_reset_nxt = (state_nxt != RUN);
    busy_nxt       = (state_nxt == START) || (state_nxt == RUN);
    done_nxt       = (state_nxt == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rcnt       <= '0;
      cycles     <= '0;
      timeout    <= 1'b0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      host_drop  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rcnt       <= rcnt_nxt;
      cycles     <= cycles_nxt;
      timeout    <= timeout_nxt;
      core_reset <= core_reset_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      host_drop  <= host_drop_nxt;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl (MAX_CYC=16, RST_CYC=2).
module tb_run_ctrl;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          host_we = 1'b0;
  logic [7:0]    host_addr = 8'h00;
  logic [7:0]    host_wdata = 8'h00;
  logic          core_done = 1'b0;
  logic          core_we = 1'b0;
  logic [7:0]    core_addr = 8'h00;
  logic [7:0]    core_wdata = 8'h00;
  logic          dm_we;
  logic [7:0]    dm_addr;
  logic [7:0]    dm_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic          host_drop;

  int n_chk  = 0;
  int n_fail = 0;

  run_ctrl #(.CW(CW), .MAX_CYC(16), .RST_CYC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .core_done  (core_done),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles),
    .host_drop  (host_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "bench time limit expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Raise req in IDLE, check two START cycles, end on the first RUN sample (cycles=0).
  task automatic start_run(input string tag);
    req = 1'b1;
    tick();
    check({tag, "_start0_busy"},  32'(busy), 32'd1);
    check({tag, "_start0_crst"},  32'(core_reset), 32'd1);
    check({tag, "_start0_cyc"},   32'(cycles), 32'd0);
    check({tag, "_start0_tmo"},   32'(timeout), 32'd0);
    tick();
    check({tag, "_start1_crst"},  32'(core_reset), 32'd1);
    tick();
    check({tag, "_run_crst"},     32'(core_reset), 32'd0);
    check({tag, "_run_busy"},     32'(busy), 32'd1);
    check({tag, "_run_cyc0"},     32'(cycles), 32'd0);
  endtask

  initial begin
    // Reset state, dm port follows host during reset.
    #1 reset = 1'b0;
    host_we = 1'b1;
    #1;
    check("rst_crst",  32'(core_reset), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_tmo",   32'(timeout), 32'd0);
    check("rst_cyc",   32'(cycles), 32'd0);
    check("rst_drop",  32'(host_drop), 32'd0);
    check("rst_dmwe1", 32'(dm_we), 32'd1);
    host_we = 1'b0;
    #1;
    check("rst_dmwe0", 32'(dm_we), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_crst", 32'(core_reset), 32'd1);

    // Host write in IDLE passes straight through; core port ignored.
    host_we = 1'b1; host_addr = 8'h01; host_wdata = 8'h05;
    core_we = 1'b1; core_addr = 8'h03; core_wdata = 8'hAA;
    #1;
    check("idle_dmwe",   32'(dm_we), 32'd1);
    check("idle_dmaddr", 32'(dm_addr), 32'h01);
    check("idle_dmdat",  32'(dm_wdata), 32'h05);
    host_we = 1'b0;
    #1;
    check("idle_core_we_blocked", 32'(dm_we), 32'd0);
    tick();
    check("idle_nodrop", 32'(host_drop), 32'd0);
    core_we = 1'b0;

    // Normal run: core_done after 10 counting RUN edges.
    start_run("r1");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("r1_run_crst", 32'(core_reset), 32'd0);
      check("r1_run_cyc",  32'(cycles), 32'(i + 1));
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("r1_done",  32'(done), 32'd1);
    check("r1_cyc",   32'(cycles), 32'd10);
    check("r1_tmo",   32'(timeout), 32'd0);
    check("r1_crst",  32'(core_reset), 32'd1);
    check("r1_busy",  32'(busy), 32'd0);

    // req held high in DONE: no restart.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_done", 32'(done), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
    end
    req = 1'b0;
    tick();
    check("back_idle_done", 32'(done), 32'd0);
    check("back_idle_busy", 32'(busy), 32'd0);
    check("back_idle_cyc",  32'(cycles), 32'd10);

    // Watchdog run: DONE on the 16th RUN edge with cycles=16.
    start_run("wd");
    for (int i = 0; i < 15; i++) begin
      tick();
      check("wd_busy", 32'(busy), 32'd1);
      check("wd_cyc",  32'(cycles), 32'(i + 1));
    end
    tick();
    check("wd_done", 32'(done), 32'd1);
    check("wd_tmo",  32'(timeout), 32'd1);
    check("wd_cyc16", 32'(cycles), 32'd16);
    req = 1'b0;
    tick();
    check("wd_idle_tmo_hold", 32'(timeout), 32'd1);

    // core_done on the same edge the watchdog would fire: core_done wins.
    start_run("cd");
    for (int i = 0; i < 15; i++) tick();
    check("cd_cyc15", 32'(cycles), 32'd15);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("cd_done", 32'(done), 32'd1);
    check("cd_tmo",  32'(timeout), 32'd0);
    check("cd_cyc",  32'(cycles), 32'd15);
    req = 1'b0;
    tick();

    // Memory arbitration in RUN.
    start_run("mx");
    host_we = 1'b1; host_addr = 8'h02; host_wdata = 8'h11;
    core_we = 1'b1; core_addr = 8'h03; core_wdata = 8'hAA;
    #1;
    check("mx_dmwe",   32'(dm_we), 32'd1);
    check("mx_dmaddr", 32'(dm_addr), 32'h03);
    check("mx_dmdat",  32'(dm_wdata), 32'hAA);
    tick();
    check("mx_drop1", 32'(host_drop), 32'd1);
    host_we = 1'b0; core_we = 1'b0;
    tick();
    check("mx_drop0", 32'(host_drop), 32'd0);
    host_we = 1'b1;
    #1;
    check("mx_host_we_ignored", 32'(dm_we), 32'd0);
    core_we = 1'b1;
    host_addr = 8'h07;
    tick();

    // Async reset mid-RUN: takes effect before the next clock edge.
    core_we = 1'b0;
    host_we = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("ar_crst",   32'(core_reset), 32'd1);
    check("ar_busy",   32'(busy), 32'd0);
    check("ar_cyc",    32'(cycles), 32'd0);
    check("ar_drop",   32'(host_drop), 32'd0);
    check("ar_dmwe",   32'(dm_we), 32'd1);
    check("ar_dmaddr", 32'(dm_addr), 32'h07);
    host_we = 1'b0;
    req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("ar_idle_busy", 32'(busy), 32'd0);
    check("ar_idle_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
